int_sequencer: RTL and testbench
================================

Name: int_sequencer

Overview:
- Interrupt controller/sequencer for the fetch/decode front end.
- Latches edge-triggered interrupt requests, applies a programmable mask and fixed priority, and waits for a safe decode slot.
- On a take it flushes the decode instruction, redirects fetch to a per-source vector, and saves the return PC.
- Tracks one in-service interrupt, with no nesting, until a return-from-interrupt retires.

Parameters:
- NUM_IRQ, 4, number of interrupt sources (1..16).
- VECTOR_BASE, 32'h0000_0100, address of the source-0 handler.
- VECTOR_STRIDE, 32'h0000_0010, byte spacing between handler vectors.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq  in  NUM_IRQ  interrupt request lines; synchronous to clk; rising edge = request.
- cfg_wr  in  1  mask write strobe.
- cfg_mask  in  NUM_IRQ  new mask value; bit=1 enables the source.
- id_valid  in  1  decode stage holds a real instruction, not a bubble.
- id_pc_plus_4  in  32  pc_plus_4 of the instruction in decode.
- id_branch_sel  in  1  decode is redirecting fetch this cycle.
- stall  in  1  front end stalled this cycle.
- reti_retire  in  1  return-from-interrupt retired in WB, 1-cycle pulse.
- int_take  out  1  1-cycle take pulse: flush decode and redirect fetch to int_vector.
- int_vector  out  32  handler address; valid while int_take=1.
- int_id  out  $clog2(NUM_IRQ) (min 1)  source being taken or serviced.
- epc  out  32  saved return PC.
- in_service  out  1  handler executing.
- pending  out  NUM_IRQ  latched, unserviced requests.
- mask  out  NUM_IRQ  current mask register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pending=0; mask=0; irq_q=0; epc=0; int_id=0; in_service=0; int_take=0.
- Edge detect: irq_q <= irq each cycle; rise = irq & ~irq_q.
- Pending update: pending <= (pending & ~clr) | rise.
  - clr is the one-hot of int_id in a take cycle, otherwise 0.
  - A set and a clear of the same bit in the same cycle leaves the bit set.
- Mask: mask <= cfg_mask when cfg_wr=1.
- Definitions:
  - req = pending & mask.
  - Winner = lowest-index set bit of req.
- FSM, states IDLE, ARMED, SERVICE:
  - IDLE: if |req, then int_id <= winner and go to ARMED.
  - ARMED: each cycle re-evaluate.
    - If req=0 (masked away): go to IDLE and take nothing.
    - Else int_id <= winner, so a higher-priority arrival preempts.
    - safe = id_valid & ~stall & ~id_branch_sel.
    - When safe=1: int_take=1 combinationally (Mealy) for the registered int_id.
    - On a take: epc <= id_pc_plus_4 - 4, the squashed instruction re-executes after return. Also clear pending[int_id], set in_service=1, and go to SERVICE.
  - SERVICE: in_service=1. New requests accumulate in pending.
    - On reti_retire: in_service <= 0 and go to IDLE. Any remaining req is re-armed from IDLE the next cycle.
  - reti_retire in IDLE or ARMED is ignored.
- int_vector = VECTOR_BASE + int_id*VECTOR_STRIDE, 32-bit modulo 2^32.
- int_take is never asserted outside ARMED, and is never asserted for 2 consecutive cycles.
- Latency:
  - Fastest take is 2 cycles after the irq rising edge: edge cycle, then IDLE->ARMED, then take in ARMED if safe.
  - The take is unbounded while unsafe.
- epc, int_id hold their values in SERVICE.
- Reset mid-operation returns to IDLE and drops pending and in_service.

Decomposition:
- Shared package:
  - State typedef int_state_t {IDLE, ARMED, SERVICE}.
  - Default VECTOR_BASE/VECTOR_STRIDE constants.
- One natural sub-module: int_prio_enc, a parameterised lowest-index priority encoder returning winner and any.
- Edge detect, mask, pending and the FSM stay in int_sequencer.

Test Plan:
1. Basic take:
   - Stimulus: mask=4'b1111; pulse irq[2] high. Decode stays safe with id_pc_plus_4=32'h0000_0044.
   - Required: int_take exactly 2 cycles after the edge, int_vector=32'h0000_0120, epc=32'h0000_0040, pending[2]=0, in_service=1.
2. Priority:
   - Stimulus: rising edges on irq[3] and irq[1] in the same cycle.
   - Required: take int_id=1, vector 32'h0000_0110; pending[3] remains 1.
   - Then stimulus: reti_retire.
   - Required: a second take with int_id=3, vector 32'h0000_0130.
3. Unsafe hold-off:
   - Stimulus: in ARMED, hold stall=1 for 3 cycles, then id_branch_sel=1 for 1 cycle, then id_valid=0 for 1 cycle, then all safe.
   - Required: int_take=0 throughout the unsafe cycles, then a single 1-cycle pulse.
4. Mask-away:
   - Stimulus: while ARMED on irq[0], cfg_wr with cfg_mask=0.
   - Required: return to IDLE with no take; pending[0] stays 1.
   - Then stimulus: re-enable the mask.
   - Required: take with vector 32'h0000_0100.
5. No nesting and same-cycle set/clear:
   - Stimulus: in SERVICE, raise irq[0].
   - Required: no take until reti_retire; take 2 cycles after the retire.
   - Stimulus: a new edge on the same source in the take cycle.
   - Required: pending stays 1.
6. Async reset:
   - Stimulus: assert rst_n=0 mid-SERVICE between clock edges.
   - Required: in_service, pending, mask, epc=0 immediately, with no int_take after release.

Source files
------------

// File: rtl/int_sequencer_pkg.sv
// Shared types and defaults for the interrupt sequencer.
// State encoding, default vector layout and the int_id width helper.
package int_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

  localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VECTOR_STRIDE = 32'h0000_0010;

  // A single source still needs a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index priority encoder: o_idx is the lowest set bit of i_req, o_any = |i_req.
// Purely combinational, zero latency, no flow control.
module int_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = W'(i);
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Edge-latched, masked, fixed-priority interrupt sequencer with one non-nesting service slot.
// Take fires 2 cycles after an irq edge at the earliest; held off indefinitely while decode is unsafe.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int          NUM_IRQ       = 4,
  parameter logic [31:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter logic [31:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE,
  localparam int         IDW           = id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               cfg_wr,
  input  logic [NUM_IRQ-1:0] cfg_mask,
  input  logic               id_valid,
  input  logic [31:0]        id_pc_plus_4,
  input  logic               id_branch_sel,
  input  logic               stall,
  input  logic               reti_retire,
  output logic               int_take,
  output logic [31:0]        int_vector,
  output logic [IDW-1:0]     int_id,
  output logic [31:0]        epc,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  int_state_t         r_state;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [IDW-1:0]     r_int_id;
  logic [31:0]        r_epc;
  logic               r_in_service;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_req;
  logic [NUM_IRQ-1:0] w_clr;
  logic [IDW-1:0]     w_winner;
  logic               w_any;
  logic               w_safe;
  logic               w_take;

  assign w_rise = irq & ~r_irq_q;
  assign w_req  = r_pending & r_mask;
  assign w_safe = id_valid & ~stall & ~id_branch_sel;
  // Mealy take: the registered int_id is the source committed to this slot.
  assign w_take = (r_state == ARMED) & w_any & w_safe;

  int_prio_enc #(
    .N(NUM_IRQ),
    .W(IDW)
  ) u_prio (
    .i_req(w_req),
    .o_idx(w_winner),
    .o_any(w_any)
  );

  always_comb begin
    w_clr = '0;
    if (w_take) w_clr[r_int_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_irq_q      <= '0;
      r_pending    <= '0;
      r_mask       <= '0;
      r_int_id     <= '0;
      r_epc        <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_irq_q   <= irq;
      // A fresh edge wins over the take-cycle clear of the same bit.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (cfg_wr) r_mask <= cfg_mask;

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_int_id <= w_winner;
            r_state  <= ARMED;
          end
        end
        ARMED: begin
          if (!w_any) begin
            r_state <= IDLE;
          end else if (w_take) begin
            r_epc        <= id_pc_plus_4 - 32'd4;
            r_in_service <= 1'b1;
            r_state      <= SERVICE;
          end else begin
            r_int_id <= w_winner;
          end
        end
        SERVICE: begin
          if (reti_retire) begin
            r_in_service <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign int_take   = w_take;
  assign int_vector = VECTOR_BASE + 32'(r_int_id) * VECTOR_STRIDE;
  assign int_id     = r_int_id;
  assign epc        = r_epc;
  assign in_service = r_in_service;
  assign pending    = r_pending;
  assign mask       = r_mask;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: vector table, directed corner sequences, then random traffic vs a reference model.
module tb_int_sequencer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq;
  logic         cfg_wr;
  logic [N-1:0] cfg_mask;
  logic         id_valid;
  logic [31:0]  id_pc_plus_4;
  logic         id_branch_sel;
  logic         stall;
  logic         reti_retire;
  logic         int_take;
  logic [31:0]  int_vector;
  logic [1:0]   int_id;
  logic [31:0]  epc;
  logic         in_service;
  logic [N-1:0] pending;
  logic [N-1:0] mask;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_sequencer #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .cfg_wr(cfg_wr), .cfg_mask(cfg_mask),
    .id_valid(id_valid), .id_pc_plus_4(id_pc_plus_4), .id_branch_sel(id_branch_sel),
    .stall(stall), .reti_retire(reti_retire), .int_take(int_take),
    .int_vector(int_vector), .int_id(int_id), .epc(epc), .in_service(in_service),
    .pending(pending), .mask(mask)
  );

  typedef struct {
    int          src;
    logic [31:0] pc;
    logic [31:0] exp_vec;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq = '0; cfg_wr = 1'b0; cfg_mask = '0; id_valid = 1'b1;
    id_pc_plus_4 = 32'h44; id_branch_sel = 1'b0; stall = 1'b0; reti_retire = 1'b0;
  endtask

  task automatic set_mask(input logic [N-1:0] m);
    cfg_wr = 1'b1; cfg_mask = m;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic retire();
    reti_retire = 1'b1;
    step();
    reti_retire = 1'b0;
  endtask

  // Reference model state
  logic [N-1:0] m_irq_q, m_pend, m_mask;
  logic         m_svc, m_armed;
  logic [1:0]   m_id;
  logic [31:0]  m_epc;

  function automatic logic [1:0] lowest(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return 2'(i);
    return 2'd0;
  endfunction

  initial begin
    logic [N-1:0] req, rise, clr, tog;
    logic         safe, exp_take, ok;
    logic [31:0]  exp_vec;

    tbl[0] = '{0, 32'h0000_0044, 32'h0000_0100, 32'h0000_0040};
    tbl[1] = '{2, 32'h0000_0044, 32'h0000_0120, 32'h0000_0040};
    tbl[2] = '{3, 32'h0000_1000, 32'h0000_0130, 32'h0000_0FFC};
    tbl[3] = '{1, 32'h0000_0000, 32'h0000_0110, 32'hFFFF_FFFC};

    idle_inputs();
    #12;
    check("rst_pending", 32'(pending), 0);
    check("rst_mask", 32'(mask), 0);
    check("rst_epc", epc, 0);
    check("rst_int_id", 32'(int_id), 0);
    check("rst_in_service", 32'(in_service), 0);
    check("rst_take", 32'(int_take), 0);
    rst_n = 1'b1;
    step();

    // Table: one source per row, decode always safe
    set_mask(4'hF);
    for (int r = 0; r < 4; r++) begin
      irq = 4'(1 << tbl[r].src);
      id_pc_plus_4 = tbl[r].pc;
      step();
      irq = '0;
      check("tbl_no_early_take", 32'(int_take), 0);
      step();
      check("tbl_take", 32'(int_take), 1);
      check("tbl_vector", int_vector, tbl[r].exp_vec);
      check("tbl_int_id", 32'(int_id), 32'(tbl[r].src));
      step();
      check("tbl_take_one_cycle", 32'(int_take), 0);
      check("tbl_epc", epc, tbl[r].exp_epc);
      check("tbl_in_service", 32'(in_service), 1);
      check("tbl_pending_clr", 32'(pending), 0);
      retire();
      check("tbl_retired", 32'(in_service), 0);
      step();
    end
    id_pc_plus_4 = 32'h44;

    // Priority: simultaneous edges on 3 and 1
    irq = 4'b1010;
    step();
    step();
    irq = '0;
    check("prio_take", 32'(int_take), 1);
    check("prio_id", 32'(int_id), 1);
    check("prio_vec", int_vector, 32'h110);
    step();
    check("prio_pend3", 32'(pending), 32'h8);
    retire();
    check("prio_idle_no_take", 32'(int_take), 0);
    step();
    check("prio_second_take", 32'(int_take), 1);
    check("prio_second_id", 32'(int_id), 3);
    check("prio_second_vec", int_vector, 32'h130);
    step();
    retire();
    step();

    // Unsafe hold-off: 3x stall, 1x branch, 1x bubble
    irq = 4'b0001; stall = 1'b1;
    step();
    step();
    irq = '0;
    for (int i = 0; i < 5; i++) begin
      stall = (i < 3); id_branch_sel = (i == 3); id_valid = (i != 4);
      #1;
      check("unsafe_no_take", 32'(int_take), 0);
      step();
    end
    stall = 1'b0; id_branch_sel = 1'b0; id_valid = 1'b1;
    #1;
    check("unsafe_then_take", 32'(int_take), 1);
    step();
    check("unsafe_single_pulse", 32'(int_take), 0);
    retire();
    step();

    // Mask-away while armed
    irq = 4'b0001; stall = 1'b1;
    step();
    step();
    irq = '0;
    set_mask(4'h0);
    step();
    stall = 1'b0;
    #1;
    check("maskaway_no_take", 32'(int_take), 0);
    check("maskaway_pend0", 32'(pending), 1);
    step();
    check("maskaway_still_idle", 32'(int_take), 0);
    set_mask(4'hF);
    check("remask_idle_first", 32'(int_take), 0);
    step();
    check("remask_take", 32'(int_take), 1);
    check("remask_vec", int_vector, 32'h100);
    step();

    // No nesting; then same-cycle set/clear
    irq = 4'b0001;
    step();
    irq = '0;
    for (int i = 0; i < 4; i++) begin
      check("nonest_no_take", 32'(int_take), 0);
      step();
    end
    retire();
    check("nonest_after_reti", 32'(int_take), 0);
    step();
    check("nonest_take", 32'(int_take), 1);
    check("nonest_vec", int_vector, 32'h100);
    irq = 4'b0001;
    step();
    irq = '0;
    check("setclr_pend", 32'(pending), 1);
    check("setclr_in_service", 32'(in_service), 1);

    // Async reset mid-service, between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_service", 32'(in_service), 0);
    check("arst_pending", 32'(pending), 0);
    check("arst_mask", 32'(mask), 0);
    check("arst_epc", epc, 0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("arst_no_take", 32'(int_take), 0);
    end

    // Random traffic against the reference model
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_irq_q = '0; m_pend = '0; m_mask = '0; m_svc = 1'b0; m_armed = 1'b0;
    m_id = '0; m_epc = '0;
    for (int c = 0; c < 3000; c++) begin
      tog = '0;
      for (int b = 0; b < N; b++) tog[b] = ($urandom_range(0, 7) == 0);
      irq = irq ^ tog;
      cfg_wr = ($urandom_range(0, 15) == 0);
      cfg_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      id_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      id_branch_sel = ($urandom_range(0, 5) == 0);
      reti_retire = m_svc ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 15) == 0);
      id_pc_plus_4 = $urandom;
      #1;

      req = m_pend & m_mask;
      rise = irq & ~m_irq_q;
      safe = id_valid & ~stall & ~id_branch_sel;
      exp_take = m_armed && (req != 0) && safe;
      exp_vec = 32'h100 + 32'(m_id) * 32'h10;
      ok = (int_take === exp_take) && (!exp_take || int_vector === exp_vec) &&
           (int_id === m_id) && (epc === m_epc) && (in_service === m_svc) &&
           (pending === m_pend) && (mask === m_mask);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL rand cyc %0d: take %b/%b vec %h/%h id %0d/%0d epc %h/%h svc %b/%b pend %b/%b mask %b/%b (got/exp)",
                 c, int_take, exp_take, int_vector, exp_vec, int_id, m_id, epc, m_epc,
                 in_service, m_svc, pending, m_pend, mask, m_mask);
      end

      clr = exp_take ? 4'(1 << m_id) : '0;
      if (m_svc) begin
        if (reti_retire) m_svc = 1'b0;
      end else if (exp_take) begin
        m_svc = 1'b1;
        m_epc = id_pc_plus_4 - 32'd4;
        m_armed = 1'b0;
      end else if (req != 0) begin
        m_armed = 1'b1;
        m_id = lowest(req);
      end else begin
        m_armed = 1'b0;
      end
      m_pend = (m_pend & ~clr) | rise;
      if (cfg_wr) m_mask = cfg_mask;
      m_irq_q = irq;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
